// File: rtl/soc_uart_tx_mmio_pkg.sv
// soc_uart_tx_mmio_pkg: shared register map, STATUS layout and TX FSM encoding
package soc_uart_tx_mmio_pkg;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0040_0000;
    localparam logic [2:0] UART_TXDATA = 3'h0;
    localparam logic [2:0] UART_STATUS = 3'h4;
    localparam int ST_FULL = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVF = 2;
    localparam int ST_COUNT_LSB = 8;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/soc_sync_fifo.sv
// soc_sync_fifo: synchronous FIFO with registered storage and occupancy count
module soc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == NW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    // pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + NW'(do_push) - NW'(do_pop);
        end
    end
    // storage has no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/soc_uart_tx_mmio.sv
// soc_uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and status word
module soc_uart_tx_mmio
    import soc_uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        sel,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;
    logic phase, ovf, wr, push, pop, full, empty, tick, tx_n, unused_wdata;
    logic [2:0] off, bit_idx, bit_n;
    logic [7:0] head, sh, sh_n;
    logic [NW-1:0] count;
    logic [CW-1:0] baud, baud_n;
    logic [31:0] status;
    tx_state_t state, state_n;
    assign sel = bus_addr[31:3] == BASE_ADDR[31:3];
    assign off = bus_addr[2:0];
    assign wr = phase && bus_we && sel;
    assign push = wr && off == UART_TXDATA;
    assign tick = baud == CW'(CLKS_PER_BIT - 1);
    assign unused_wdata = ^bus_wdata[31:8];
    assign bus_rdata = (sel && off == UART_STATUS) ? status : '0;
    soc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .din(bus_wdata[7:0]),
        .pop(pop),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // status word reflects registered state only, so a same-cycle store is not yet visible
    always_comb begin
        status = '0;
        status[ST_FULL] = full;
        status[ST_BUSY] = state != S_IDLE || !empty;
        status[ST_OVF] = ovf;
        status[ST_COUNT_LSB +: 8] = 8'(count);
    end
    // phase mirrors the core's FETCH/EXECUTE toggle; ovf is sticky until a STATUS store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
            ovf <= 1'b0;
        end else begin
            phase <= !phase;
            ovf <= (wr && off == UART_STATUS) ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf;
        end
    end
    // transmitter state register; the line is registered so it never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            baud <= '0;
            bit_idx <= '0;
            sh <= '0;
            uart_tx <= 1'b1;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_idx <= bit_n;
            sh <= sh_n;
            uart_tx <= tx_n;
        end
    end
    // next-state: STOP chains straight into START when more bytes are queued
    always_comb begin
        state_n = state;
        baud_n = tick ? '0 : baud + CW'(1);
        bit_n = bit_idx;
        sh_n = sh;
        pop = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                pop = !empty;
                sh_n = empty ? sh : head;
                state_n = empty ? S_IDLE : S_START;
            end
            S_START: begin
                bit_n = tick ? '0 : bit_idx;
                state_n = tick ? S_DATA : S_START;
            end
            S_DATA: begin
                sh_n = tick ? sh >> 1 : sh;
                bit_n = tick ? bit_idx + 3'd1 : bit_idx;
                state_n = (tick && bit_idx == 3'd7) ? S_STOP : S_DATA;
            end
            default: begin
                pop = tick && !empty;
                sh_n = (tick && !empty) ? head : sh;
                state_n = !tick ? S_STOP : empty ? S_IDLE : S_START;
            end
        endcase
        tx_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? sh_n[0] : 1'b1;
    end
endmodule

// File: tb/tb_soc_uart_tx_mmio.sv
// tb_soc_uart_tx_mmio: randomized and directed checks against a frame-timeline reference model
module tb_soc_uart_tx_mmio;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;
    logic        sel;
    logic        uart_tx;

    soc_uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we(bus_we),
        .bus_rdata(bus_rdata),
        .sel(sel),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // reference model: queue of waiting bytes plus cycles left in the frame on the wire
    bit         m_phase;
    bit         m_ovf;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    int         frame_left;
    int         cycle;

    // independent line receiver
    bit         rx_active;
    int         rx_t;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    int         rx_start[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic model_sel();
        return bus_addr[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!model_sel() || bus_addr[2:0] != 3'h4) return 32'h0;
        return {16'h0, 8'(q.size()), 5'h0, m_ovf, frame_left > 0 || q.size() > 0, q.size() == DEPTH};
    endfunction

    function automatic logic exp_line();
        int pos;
        if (frame_left == 0) return 1'b1;
        pos = (FRAME - frame_left) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur[pos-1];
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ovf = 0;
        q.delete();
        exp_q.delete();
        frame_left = 0;
        rx_active = 0;
    endtask

    task automatic receive();
        if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1;
                rx_t = 0;
                rx_start.push_back(cycle);
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB + CPB / 2 && rx_t < 9 * CPB && (rx_t - CPB / 2) % CPB == 0)
                rx_byte[(rx_t - CPB - CPB / 2) / CPB] = uart_tx;
            if (rx_t == 9 * CPB + CPB / 2) begin
                check("rx_stop", uart_tx, 1);
                rx_q.push_back(rx_byte);
                check("rx_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
            end
            if (rx_t == FRAME - 1) rx_active = 0;
        end
    endtask

    task automatic tick();
        bit accept;
        #1;
        check("sel", sel, model_sel());
        check("rdata", bus_rdata, exp_rdata());
        @(posedge clk);
        accept = m_phase && bus_we && model_sel();
        m_phase = !m_phase;
        if (frame_left > 0) frame_left--;
        if (frame_left == 0 && q.size() > 0) begin
            cur = q.pop_front();
            exp_q.push_back(cur);
            frame_left = FRAME;
        end
        if (accept && bus_addr[2:0] == 3'h0) begin
            if (q.size() < DEPTH) q.push_back(bus_wdata[7:0]);
            else m_ovf = 1;
        end
        if (accept && bus_addr[2:0] == 3'h4) m_ovf = 0;
        cycle++;
        #1;
        check("uart_tx", uart_tx, exp_line());
        receive();
    endtask

    task automatic store(input logic [31:0] addr, input logic [7:0] data);
        while (!m_phase) tick();
        bus_addr = addr;
        bus_wdata = {$urandom_range(0, 255), 16'h0, data};
        bus_we = 1;
        tick();
        tick();
        bus_we = 0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        bus_addr = BASE + 4;
        while ((frame_left > 0 || q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", n < max, 1);
        #1;
        check("idle_status", bus_rdata, 32'h0000_0000 | {29'h0, m_ovf, 2'b00});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0;
        int t;
        logic [9:0] fb;
        logic [31:0] addrs[4];
        addrs = '{BASE + 4, BASE + 8, BASE, 32'h1000_0004};
        cycle = 0;
        model_reset();
        reset = 1;
        bus_we = 0;
        bus_addr = BASE + 4;
        bus_wdata = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_tx", uart_tx, 1);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_sel", sel, 1);
        @(posedge clk);
        #3 reset = 0;

        // single byte 0xA5
        f0 = rx_start.size();
        store(BASE, 8'hA5);
        fb = {1'b1, 8'hA5, 1'b0};
        check("single_start", uart_tx, 0);
        for (int i = 0; i < FRAME; i++) begin
            check("single_bit", uart_tx, fb[i/CPB]);
            tick();
        end
        check("single_after", uart_tx, 1);
        wait_idle(100);
        check("single_frames", rx_start.size() - f0, 1);

        // duplicate strobe filter: we held 3 cycles from EXECUTE
        f0 = rx_start.size();
        while (!m_phase) tick();
        bus_addr = BASE;
        bus_wdata = 32'h11;
        bus_we = 1;
        tick();
        tick();
        bus_wdata = 32'h22;
        tick();
        bus_we = 0;
        wait_idle(200);
        check("dup_frames", rx_start.size() - f0, 2);
        if (rx_start.size() - f0 == 2) begin
            check("dup_gap", rx_start[f0+1] - rx_start[f0], FRAME);
            check("dup_b0", rx_q[f0], 8'h11);
            check("dup_b1", rx_q[f0+1], 8'h22);
        end

        // overflow
        f0 = rx_start.size();
        for (int i = 0; i < 6; i++) store(BASE, 8'h30 + 8'(i));
        bus_addr = BASE + 4;
        #1;
        check("ovf_status", bus_rdata, 32'h0000_0407);
        store(BASE + 4, 8'h00);
        bus_addr = BASE + 4;
        #1;
        check("ovf_clear", bus_rdata, 32'h0000_0403);
        wait_idle(400);
        check("ovf_frames", rx_start.size() - f0, 5);

        // full FIFO with a store landing on the STOP->START pop
        f0 = rx_start.size();
        for (int i = 0; i < 5; i++) store(BASE, 8'h50 + 8'(i));
        t = 0;
        while (!(frame_left == 1 && q.size() == DEPTH) && t < 200) begin
            tick();
            t++;
        end
        check("pop_edge_reached", t < 200, 1);
        store(BASE, 8'h5A);
        bus_addr = BASE + 4;
        #1;
        check("full_pop_status", bus_rdata, 32'h0000_0403);
        wait_idle(600);
        check("full_pop_frames", rx_start.size() - f0, 6);

        // read decode while idle
        bus_addr = BASE + 4;
        #1;
        check("dec_status", bus_rdata, 32'h0);
        check("dec_status_sel", sel, 1);
        bus_addr = BASE + 8;
        #1;
        check("dec_out_sel", sel, 0);
        check("dec_out_rdata", bus_rdata, 32'h0);
        bus_addr = BASE;
        #1;
        check("dec_txdata", bus_rdata, 32'h0);
        check("dec_txdata_sel", sel, 1);

        // reset during DATA bit 3
        store(BASE, 8'hC3);
        store(BASE, 8'h3C);
        t = 0;
        while (frame_left != 22 && t < 200) begin
            tick();
            t++;
        end
        check("mid_frame_reached", t < 200, 1);
        #2 reset = 1;
        #1;
        check("rst_mid_tx", uart_tx, 1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 reset = 0;
        bus_addr = BASE + 4;
        #1;
        check("rst_mid_status", bus_rdata, 32'h0);
        f0 = rx_start.size();
        repeat (100) tick();
        check("rst_no_frames", rx_start.size() - f0, 0);

        // randomized traffic
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: store(BASE, 8'($urandom_range(0, 255)));
                6: store(BASE + 4, 8'($urandom_range(0, 255)));
                7: store(BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                8: begin
                    bus_addr = BASE;
                    bus_wdata = $urandom;
                    bus_we = 1;
                    repeat ($urandom_range(1, 3)) tick();
                    bus_we = 0;
                end
                default: begin
                    bus_addr = addrs[$urandom_range(0, 3)];
                    repeat ($urandom_range(1, 30)) tick();
                end
            endcase
        end
        wait_idle(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
